// File: rtl/dot_product_issuer_if.sv
// Bus bundle for dot_product_issuer: command, operand stream, multiplier
// issue/return and result handshake. master = the issuer, slave = its environment.
interface dot_product_issuer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int PSUM_WIDTH = 20,
    parameter int LEN_WIDTH  = 8,
    parameter int ACC_WIDTH  = 28
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [LEN_WIDTH-1:0]  cmd_len;
    logic                  op_valid;
    logic                  op_ready;
    logic [DATA_WIDTH-1:0] op_a;
    logic [DATA_WIDTH-1:0] op_b;
    logic                  mul_valid;
    logic [DATA_WIDTH-1:0] mul_a;
    logic [DATA_WIDTH-1:0] mul_b;
    logic [PSUM_WIDTH-1:0] mul_rlst;
    logic                  mul_rlst_vld;
    logic                  sum_valid;
    logic                  sum_ready;
    logic [ACC_WIDTH-1:0]  sum_data;
    logic                  err_stray;

    modport master (
        input  cmd_valid, cmd_len, op_valid, op_a, op_b, mul_rlst, mul_rlst_vld, sum_ready,
        output cmd_ready, op_ready, mul_valid, mul_a, mul_b, sum_valid, sum_data, err_stray
    );

    modport slave (
        output cmd_valid, cmd_len, op_valid, op_a, op_b, mul_rlst, mul_rlst_vld, sum_ready,
        input  cmd_ready, op_ready, mul_valid, mul_a, mul_b, sum_valid, sum_data, err_stray
    );
endinterface

// File: rtl/dot_product_issuer.sv
// Dot-product issuer/collector for a fixed-latency, non-stalling signed
// multiplier. Streams N operand pairs out, sums the N products that come
// back, and holds the result on a valid/ready port.
module dot_product_issuer #(
    parameter int DATA_WIDTH  = 8,
    parameter int PSUM_WIDTH  = 20,
    parameter int LEN_WIDTH   = 8,
    parameter int ACC_WIDTH   = 28,
    parameter int MUL_LATENCY = 5
) (
    input  logic                 s_clk,
    input  logic                 s_rst,
    dot_product_issuer_if.master bus
);
    // Blanking must cover every product still in flight when reset hits.
    localparam int BLANK_W = $clog2(MUL_LATENCY + 2);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t                state;
    logic [LEN_WIDTH-1:0]  issue_cnt;
    logic [LEN_WIDTH-1:0]  ret_cnt;
    logic [ACC_WIDTH-1:0]  acc;
    logic [ACC_WIDTH-1:0]  acc_sum;
    logic [ACC_WIDTH-1:0]  prod_ext;
    logic [ACC_WIDTH-1:0]  sum_q;
    logic [BLANK_W-1:0]    blank_cnt;
    logic                  cmd_rdy_q;
    logic                  op_rdy_q;
    logic                  mul_vld_q;
    logic                  sum_vld_q;
    logic                  err_q;
    logic [DATA_WIDTH-1:0] mul_a_q;
    logic [DATA_WIDTH-1:0] mul_b_q;
    logic                  cmd_fire;
    logic                  op_fire;
    logic                  sum_fire;
    logic                  collect;
    logic                  last_ret;
    logic                  last_issue;
    logic                  stray;

    assign cmd_fire   = bus.cmd_valid & cmd_rdy_q;
    assign op_fire    = bus.op_valid & op_rdy_q;
    assign sum_fire   = sum_vld_q & bus.sum_ready;
    // Products are accepted while issuing too: early returns overlap later issues.
    assign collect    = bus.mul_rlst_vld & ((state == ISSUE) | (state == DRAIN));
    assign last_ret   = collect & (ret_cnt == LEN_WIDTH'(1));
    assign last_issue = op_fire & (issue_cnt == LEN_WIDTH'(1));
    assign stray      = bus.mul_rlst_vld & ((state == IDLE) | (state == DONE)) &
                        (blank_cnt == '0);
    assign prod_ext   = {{(ACC_WIDTH-PSUM_WIDTH){bus.mul_rlst[PSUM_WIDTH-1]}}, bus.mul_rlst};
    assign acc_sum    = acc + prod_ext;

    assign bus.cmd_ready = cmd_rdy_q;
    assign bus.op_ready  = op_rdy_q;
    assign bus.mul_valid = mul_vld_q;
    assign bus.mul_a     = mul_a_q;
    assign bus.mul_b     = mul_b_q;
    assign bus.sum_valid = sum_vld_q;
    assign bus.sum_data  = sum_q;
    assign bus.err_stray = err_q;

    // Control FSM with issue/return counters, accumulator and registered outputs
    always_ff @(posedge s_clk) begin
        if (s_rst) begin
            state     <= IDLE;
            issue_cnt <= '0;
            ret_cnt   <= '0;
            acc       <= '0;
            blank_cnt <= BLANK_W'(MUL_LATENCY + 1);
            cmd_rdy_q <= 1'b0;
            op_rdy_q  <= 1'b0;
            mul_vld_q <= 1'b0;
            mul_a_q   <= '0;
            mul_b_q   <= '0;
            sum_vld_q <= 1'b0;
            sum_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            if (blank_cnt != '0)
                blank_cnt <= blank_cnt - BLANK_W'(1);
            if (stray)
                err_q <= 1'b1;
            // Operands hold their last value on idle cycles; only valid pulses.
            mul_vld_q <= op_fire;
            if (op_fire) begin
                mul_a_q   <= bus.op_a;
                mul_b_q   <= bus.op_b;
                issue_cnt <= issue_cnt - LEN_WIDTH'(1);
            end
            if (collect) begin
                acc     <= acc_sum;
                ret_cnt <= ret_cnt - LEN_WIDTH'(1);
            end
            case (state)
                IDLE: begin
                    cmd_rdy_q <= 1'b1;
                    if (cmd_fire) begin
                        cmd_rdy_q <= 1'b0;
                        acc       <= '0;
                        if (bus.cmd_len == '0) begin
                            state     <= DONE;
                            sum_vld_q <= 1'b1;
                            sum_q     <= '0;
                        end else begin
                            state     <= ISSUE;
                            issue_cnt <= bus.cmd_len;
                            ret_cnt   <= bus.cmd_len;
                            op_rdy_q  <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (last_ret) begin
                        state     <= DONE;
                        op_rdy_q  <= 1'b0;
                        sum_vld_q <= 1'b1;
                        sum_q     <= acc_sum;
                    end else if (last_issue) begin
                        state    <= DRAIN;
                        op_rdy_q <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (last_ret) begin
                        state     <= DONE;
                        sum_vld_q <= 1'b1;
                        sum_q     <= acc_sum;
                    end
                end
                DONE: begin
                    if (sum_fire) begin
                        state     <= IDLE;
                        sum_vld_q <= 1'b0;
                        cmd_rdy_q <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dot_product_issuer.sv
// Scoreboard bench for dot_product_issuer: a latency-5 multiplier model, a
// stimulus thread pushing expected sums/pairs, and a negedge monitor that
// pops and compares whenever the DUT presents an output.
module tb_dot_product_issuer;
    localparam int DW  = 8;
    localparam int PW  = 20;
    localparam int LW  = 8;
    localparam int AW  = 28;
    localparam int LAT = 5;

    logic s_clk = 1'b0;
    logic s_rst = 1'b1;

    dot_product_issuer_if #(.DATA_WIDTH(DW), .PSUM_WIDTH(PW), .LEN_WIDTH(LW), .ACC_WIDTH(AW)) ifc ();

    dot_product_issuer #(
        .DATA_WIDTH(DW), .PSUM_WIDTH(PW), .LEN_WIDTH(LW), .ACC_WIDTH(AW), .MUL_LATENCY(LAT)
    ) dut (
        .s_clk(s_clk),
        .s_rst(s_rst),
        .bus  (ifc)
    );

    always #5 s_clk = ~s_clk;

    typedef struct {
        logic signed [AW-1:0] sum;
        int                   len;
    } exp_t;

    exp_t                exp_q[$];
    logic [2*DW-1:0]     iss_q[$];
    logic signed [DW-1:0] pa[$];
    logic signed [DW-1:0] pb[$];

    int n_cmp = 0;
    int n_bad = 0;
    int n_done = 0;
    int ncyc = 0;
    int last_op = 0;
    int ready_hold = 0;
    bit rand_ready = 1'b0;
    logic [5:0] pat6 = 6'b101001;

    // Multiplier model: fixed latency, no stalls
    logic [LAT:1]         mvld = '0;
    logic [LAT:1][PW-1:0] mprod = '0;
    logic                 inject = 1'b0;
    logic signed [DW-1:0] ma, mb;
    assign ma = ifc.mul_a;
    assign mb = ifc.mul_b;
    always @(posedge s_clk) begin
        mvld  <= {mvld[LAT-1:1], ifc.mul_valid};
        mprod <= {mprod[LAT-1:1], PW'(int'(ma) * int'(mb))};
    end
    assign ifc.mul_rlst_vld = mvld[LAT] | inject;
    assign ifc.mul_rlst     = inject ? 20'h5A5A5 : mprod[LAT];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d", name, $signed(act), $signed(exp));
        end
    endtask

    task automatic bad(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: event with nothing expected / bound expired", name);
    endtask

    // Monitor: mul issue scoreboard, sum scoreboard, latency and hold rules
    logic            prev_v = 1'b0;
    logic            prev_r = 1'b0;
    logic [AW-1:0]   held = '0;
    logic signed [63:0] sd_ext;
    always @(negedge s_clk) begin
        ncyc++;
        if (s_rst) begin
            prev_v = 1'b0;
            prev_r = 1'b0;
        end else begin
            if (ifc.mul_valid) begin
                if (iss_q.size() == 0) bad("mul_stray_pulse");
                else check("mul_ab", {48'b0, ifc.mul_a, ifc.mul_b}, {48'b0, iss_q.pop_front()});
            end
            if (ifc.op_valid && ifc.op_ready) begin
                iss_q.push_back({ifc.op_a, ifc.op_b});
                last_op = ncyc;
            end
            if (ifc.cmd_ready || ifc.op_ready)
                check("ready_excl", {63'b0, ifc.cmd_ready & ifc.op_ready}, 64'd0);
            if (prev_v && !prev_r) begin
                check("sum_valid_hold", {63'b0, ifc.sum_valid}, 64'd1);
                check("sum_stable", {36'b0, ifc.sum_data}, {36'b0, held});
            end
            if (ifc.sum_valid && !prev_v) begin
                if (exp_q.size() == 0) bad("sum_unexpected");
                else if (exp_q[0].len > 0) check("sum_latency", 64'(ncyc - last_op), 64'd7);
            end
            if (ifc.sum_valid && ifc.sum_ready && exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                sd_ext = $signed(ifc.sum_data);
                check("sum_data", sd_ext, 64'(e.sum));
                n_done++;
            end
            prev_v = ifc.sum_valid;
            prev_r = ifc.sum_ready;
            held   = ifc.sum_data;
        end
    end

    // Result-side backpressure: hold low for ready_hold valid cycles, else 1 or random
    initial begin
        ifc.sum_ready = 1'b0;
        forever begin
            @(posedge s_clk); #1;
            if (ready_hold > 0) begin
                ifc.sum_ready = 1'b0;
                if (ifc.sum_valid) ready_hold--;
            end else begin
                ifc.sum_ready = rand_ready ? 1'($urandom % 2) : 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge s_clk); #1;
    endtask

    task automatic do_reset(input int cycles, input bit chk);
        s_rst = 1'b1;
        ifc.cmd_valid = 1'b0;
        ifc.op_valid  = 1'b0;
        inject = 1'b0;
        exp_q.delete();
        iss_q.delete();
        repeat (cycles) tick();
        if (chk) begin
            @(negedge s_clk);
            check("rst_cmd_ready", {63'b0, ifc.cmd_ready}, 64'd0);
            check("rst_op_ready",  {63'b0, ifc.op_ready}, 64'd0);
            check("rst_mul_valid", {63'b0, ifc.mul_valid}, 64'd0);
            check("rst_mul_ab",    {48'b0, ifc.mul_a, ifc.mul_b}, 64'd0);
            check("rst_sum_valid", {63'b0, ifc.sum_valid}, 64'd0);
            check("rst_sum_data",  {36'b0, ifc.sum_data}, 64'd0);
            check("rst_err_stray", {63'b0, ifc.err_stray}, 64'd0);
            tick();
        end
        s_rst = 1'b0;
    endtask

    task automatic send_cmd(input int len);
        int k = 0;
        ifc.cmd_valid = 1'b1;
        ifc.cmd_len   = LW'(len);
        @(negedge s_clk);
        while (!ifc.cmd_ready && k < 50) begin
            @(negedge s_clk);
            k++;
        end
        if (!ifc.cmd_ready) bad("cmd_timeout");
        tick();
        ifc.cmd_valid = 1'b0;
    endtask

    // mode 0: op_valid held high, 1: random, 2: 1-0-0-1-0-1 pattern
    task automatic run_cmd(input int len, input int mode, input int hold);
        longint s = 0;
        exp_t e;
        int idx = 0;
        int step = 0;
        int k = 0;
        int d0 = n_done;
        for (int i = 0; i < len; i++) s += longint'(pa[i]) * longint'(pb[i]);
        e.sum = AW'(s);
        e.len = len;
        exp_q.push_back(e);
        ready_hold = hold;
        send_cmd(len);
        while (idx < len && step < 4000) begin
            case (mode)
                0:       ifc.op_valid = 1'b1;
                1:       ifc.op_valid = 1'($urandom % 2);
                default: ifc.op_valid = pat6[step % 6];
            endcase
            ifc.op_a = pa[idx];
            ifc.op_b = pb[idx];
            @(negedge s_clk);
            if (ifc.op_valid && ifc.op_ready) idx++;
            tick();
            step++;
        end
        ifc.op_valid = 1'b0;
        if (idx < len) bad("op_timeout");
        while (n_done == d0 && k < 3000) begin
            @(negedge s_clk); #1;
            k++;
        end
        if (n_done == d0) bad("sum_timeout");
        pa.delete();
        pb.delete();
    endtask

    task automatic add_pair(input int a, input int b);
        pa.push_back(DW'(a));
        pb.push_back(DW'(b));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ifc.cmd_valid = 1'b0;
        ifc.cmd_len   = '0;
        ifc.op_valid  = 1'b0;
        ifc.op_a      = '0;
        ifc.op_b      = '0;

        // Reset values, then blanked and unblanked stray returns
        do_reset(8, 1'b1);
        @(negedge s_clk);
        @(negedge s_clk);
        check("cmd_ready_after_rst", {63'b0, ifc.cmd_ready}, 64'd1);
        tick();
        tick();
        inject = 1'b1;
        tick();
        inject = 1'b0;
        @(negedge s_clk);
        check("stray_blanked", {63'b0, ifc.err_stray}, 64'd0);
        repeat (6) tick();
        inject = 1'b1;
        tick();
        inject = 1'b0;
        @(negedge s_clk);
        check("stray_flagged", {63'b0, ifc.err_stray}, 64'd1);
        repeat (3) @(negedge s_clk);
        check("stray_sticky", {63'b0, ifc.err_stray}, 64'd1);

        do_reset(3, 1'b0);
        @(negedge s_clk);
        check("stray_cleared", {63'b0, ifc.err_stray}, 64'd0);
        tick();

        // Length 1: -3*7
        add_pair(-3, 7);
        run_cmd(1, 0, 0);

        // Streaming four pairs, including extremes
        add_pair(1, 2); add_pair(-4, 5); add_pair(127, 127); add_pair(-128, -128);
        run_cmd(4, 0, 0);

        // Bursty operands
        add_pair(-7, 9); add_pair(100, -3); add_pair(-128, 127);
        run_cmd(3, 2, 0);

        // Zero length with result backpressure
        run_cmd(0, 0, 5);
        @(negedge s_clk);
        check("idle_after_zero", {63'b0, ifc.cmd_ready}, 64'd1);
        tick();

        // Abort mid-operation: in-flight products must be dropped silently
        send_cmd(8);
        ifc.op_valid = 1'b1;
        ifc.op_a = 8'sd11;
        ifc.op_b = -8'sd5;
        repeat (4) tick();
        do_reset(2, 1'b0);
        repeat (15) @(negedge s_clk);
        check("abort_no_err", {63'b0, ifc.err_stray}, 64'd0);
        check("abort_no_sum", {63'b0, ifc.sum_valid}, 64'd0);
        check("abort_cmd_ready", {63'b0, ifc.cmd_ready}, 64'd1);
        tick();

        // Randomised commands with random operand gaps and result backpressure
        rand_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            int n;
            n = $urandom_range(1, 16);
            for (int i = 0; i < n; i++) add_pair(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
            run_cmd(n, 1, 0);
        end
        rand_ready = 1'b0;

        // Maximum length: 255 * 16384
        for (int i = 0; i < 255; i++) add_pair(-128, -128);
        run_cmd(255, 0, 0);

        repeat (10) @(negedge s_clk);
        check("end_no_err", {63'b0, ifc.err_stray}, 64'd0);
        check("end_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/dot_product_issuer.md
# dot_product_issuer

Initiator and collector for the pipelined signed multiplier unit used in simulation and in the systolic datapath. It accepts a dot-product command of length N and streams N operand pairs into the multiplier on `mul_valid/mul_a/mul_b`. It accumulates the N returned products from `mul_rlst/mul_rlst_vld` and presents the signed sum on a valid/ready result port. It owns the issue side of the multiplier protocol, which has no backpressure and a fixed latency.

## Interface
- DATA_WIDTH, 8: operand width; signed two's complement.
- PSUM_WIDTH, 20: multiplier product width.
- LEN_WIDTH, 8: width of the command length field.
- ACC_WIDTH, 28: accumulator width. Must be ≥ PSUM_WIDTH+LEN_WIDTH, so no overflow is possible.
- MUL_LATENCY, 5: cycles from `mul_valid` high to the matching `mul_rlst_vld` high. Fixed, no stalls.

Ports:
- s_clk, in, 1: single clock. All logic is on the rising edge.
- s_rst, in, 1: reset. Synchronous and active-high.
- cmd_valid, in, 1 / cmd_ready, out, 1 / cmd_len, in, LEN_WIDTH: command handshake. `cmd_len` is the number of operand pairs.
- op_valid, in, 1 / op_ready, out, 1: operand stream handshake.
- op_a, op_b, in, DATA_WIDTH: operand pair.
- mul_valid, out, 1 / mul_a, out, DATA_WIDTH / mul_b, out, DATA_WIDTH: drive to the multiplier. All are registered.
- mul_rlst, in, PSUM_WIDTH / mul_rlst_vld, in, 1: product return from the multiplier.
- sum_valid, out, 1 / sum_ready, in, 1 / sum_data, out, ACC_WIDTH: result handshake.
- err_stray, out, 1: sticky flag. Set by an unexpected product return.

## Operation
- State machine states: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - `cmd_ready`=1.
  - On handshake with `cmd_len`=0: clear acc, go to DONE.
  - On handshake with `cmd_len`≠0: load issue_cnt=ret_cnt=`cmd_len`, clear acc, go to ISSUE.
- ISSUE:
  - `op_ready`=1 unconditionally.
  - Each op handshake registers `mul_valid`=1, `mul_a`=`op_a`, `mul_b`=`op_b` for the next cycle, and decrements issue_cnt.
  - The handshake that takes issue_cnt from 1 to 0 moves the FSM to DRAIN.
  - Cycles without a handshake drive `mul_valid`=0. `mul_a`/`mul_b` hold their last value.
- Collection, in ISSUE and DRAIN:
  - Each `mul_rlst_vld` adds sign-extended `mul_rlst` to acc and decrements ret_cnt.
  - The return that takes ret_cnt from 1 to 0 moves the FSM to DONE.
  - This is legal in ISSUE, because early products return while later pairs are still issuing.
- DONE:
  - `sum_valid`=1 and `sum_data`=acc, held stable until `sum_ready`.
  - On handshake, go to IDLE.
- Stray returns: a `mul_rlst_vld` in IDLE or DONE is dropped, acc is unchanged, and `err_stray` is set. Exception: returns in the blanking window are dropped without setting the flag.
- Blanking window: a counter loaded with MUL_LATENCY+1 by reset and decremented to 0. Products in flight from an aborted operation are dropped silently.
- `err_stray` clears only on reset.

## Timing
- Reset values, held while `s_rst`=1:
  - State IDLE.
  - `cmd_ready`=0 during reset, 1 from the first cycle after.
  - `op_ready`=0, `mul_valid`=0, `mul_a`=`mul_b`=0.
  - `sum_valid`=0, `sum_data`=0.
  - `err_stray`=0, acc=0, blanking counter=MUL_LATENCY+1.
- Reset mid-operation aborts immediately. No result is produced.
- Latency through the block:
  - Op handshake at edge t gives `mul_valid` high in cycle t+1.
  - The product returns at t+1+MUL_LATENCY.
  - The last return at edge r gives `sum_valid` high from cycle r+1.
- Length-1 command: `sum_valid` rises 1+MUL_LATENCY+1 = 7 cycles after the op handshake.
- Full throughput: one pair per cycle. A length-N command with op_valid held high ends with `sum_valid` at op_start+N+6.
- Handshakes complete on the edge where valid and ready are both 1.
- `cmd_ready` and `op_ready` are never 1 at the same time.
- `sum_valid` does not drop without `sum_ready`. `sum_data` is stable while `sum_valid`=1.
- Simultaneous events in ISSUE: an op handshake and a product return in the same cycle are both processed, and the counters update independently.
- Back-to-back commands: the earliest next `cmd_ready` is the cycle after the sum handshake.

## Test plan
- Reset mid-operation:
  - Stimulus: reset, then a stray `mul_rlst_vld` pulse 3 cycles after reset deassert, then another 10 cycles after.
  - Required: `err_stray`=0 after the first pulse and =1 after the second. All outputs are 0 during reset.
- Length 1:
  - Stimulus: cmd_len=1, op_a=-3, op_b=7, with a multiplier model of latency 5.
  - Required: `mul_valid` is high exactly 1 cycle. `sum_valid` rises 7 cycles after the op handshake with `sum_data`=-21.
- Streaming:
  - Stimulus: cmd_len=4, pairs (1,2),(−4,5),(127,127),(−128,−128), op_valid held high.
  - Required: sum=2−20+16129+16384=32495. `sum_valid` rises at op_start+10.
- Bursty operands:
  - Stimulus: cmd_len=3, op_valid toggled 1-0-0-1-0-1.
  - Required: `mul_valid` mirrors the handshakes one cycle later. The FSM stays in DRAIN until the third return. The result is correct.
- Zero length and backpressure:
  - Stimulus: cmd_len=0, with sum_ready low for 5 cycles.
  - Required: `sum_valid`=1, `sum_data`=0 held for 5 cycles. No `mul_valid` pulses. The FSM returns to IDLE after the handshake.
- Maximum length:
  - Stimulus: cmd_len=255, all pairs (−128,−128).
  - Required: `sum_data`=255×16384=4177920, with no overflow in ACC_WIDTH=28.
